// File: rtl/icache_refill_axi.sv
// icache_refill_axi: AXI4 read-burst master that refills one instruction cache line per miss
module icache_refill_axi #(
  parameter int LINE_BYTES = 64,
  parameter int DATA_W = 64,
  parameter int AXI_ID = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              refill_req,
  input  logic [63:0]       refill_addr,
  output logic [DATA_W-1:0] beat_data,
  output logic              beat_valid,
  input  logic              beat_ready,
  output logic [2:0]        beat_idx,
  output logic              line_done,
  output logic              line_err,
  output logic              busy,
  output logic              arvalid,
  input  logic              arready,
  output logic [63:0]       araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [3:0]        arid,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast
);
  localparam int BEATS = LINE_BYTES * 8 / DATA_W;
  localparam logic [2:0] LAST = 3'(BEATS - 1);
  typedef enum logic [2:0] {IDLE, AR, R, DRAIN, DONE} state_t;
  state_t state;
  logic [2:0] cnt;
  logic err;
  logic xfer;
  logic bad;
  assign xfer = rvalid && rready;
  assign bad = err || (rresp != 2'b00);
  assign rready = (state == R && beat_ready) || state == DRAIN;
  assign beat_valid = state == R && rvalid;
  assign beat_data = rdata;
  assign beat_idx = cnt;
  assign arlen = 8'(BEATS - 1);
  assign arsize = 3'($clog2(DATA_W / 8));
  assign arburst = 2'b01;
  assign arid = 4'(AXI_ID);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      arvalid <= 1'b0;
      busy <= 1'b0;
      line_done <= 1'b0;
      line_err <= 1'b0;
      araddr <= '0;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (refill_req && !line_done && !line_err) begin
          araddr <= refill_addr & ~64'(LINE_BYTES - 1);
          cnt <= '0;
          err <= 1'b0;
          busy <= 1'b1;
          arvalid <= 1'b1;
          state <= AR;
        end
        AR: if (arready) begin
          arvalid <= 1'b0;
          state <= R;
        end
        R: if (xfer) begin
          err <= bad || (rlast != (cnt == LAST));
          if (rlast) begin
            state <= DONE;
            line_done <= !bad && cnt == LAST;
            line_err <= bad || cnt != LAST;
          end else if (cnt == LAST) begin
            state <= DRAIN;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        DRAIN: if (rvalid && rlast) begin
          state <= DONE;
          line_err <= 1'b1;
        end
        DONE: begin
          line_done <= 1'b0;
          line_err <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_icache_refill_axi.sv
// tb_icache_refill_axi: directed bench driving an AXI slave model against icache_refill_axi
module tb_icache_refill_axi;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic refill_req = 1'b0;
  logic [63:0] refill_addr = '0;
  logic [63:0] beat_data;
  logic beat_valid;
  logic beat_ready = 1'b1;
  logic [2:0] beat_idx;
  logic line_done;
  logic line_err;
  logic busy;
  logic arvalid;
  logic arready = 1'b0;
  logic [63:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic [3:0] arid;
  logic rvalid = 1'b0;
  logic rready;
  logic [63:0] rdata = '0;
  logic [1:0] rresp = 2'b00;
  logic rlast = 1'b0;
  int checks = 0;
  int errors = 0;
  icache_refill_axi dut (
    .clk(clk), .rst(rst), .refill_req(refill_req), .refill_addr(refill_addr),
    .beat_data(beat_data), .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_idx(beat_idx),
    .line_done(line_done), .line_err(line_err), .busy(busy),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arid(arid), .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .rresp(rresp), .rlast(rlast)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic check_reset(input string tag);
    check({tag, "/arvalid"}, 64'(arvalid), 64'd0);
    check({tag, "/rready"}, 64'(rready), 64'd0);
    check({tag, "/beat_valid"}, 64'(beat_valid), 64'd0);
    check({tag, "/line_done"}, 64'(line_done), 64'd0);
    check({tag, "/line_err"}, 64'(line_err), 64'd0);
    check({tag, "/busy"}, 64'(busy), 64'd0);
    check({tag, "/beat_idx"}, 64'(beat_idx), 64'd0);
    check({tag, "/araddr"}, araddr, 64'd0);
  endtask
  task automatic run(input string tag, input logic [63:0] addr, input logic [63:0] exp_ar,
                     input int dly, input int bp, input int nb, input int last_i, input int err_b,
                     input int exp_deliv, input int exp_drain, input int exp_done, input int exp_err,
                     input int exp_lat, input int rst_at);
    int aw = 0;
    int sb = 0;
    int deliv = 0;
    int drain = 0;
    int nd = 0;
    int ne = 0;
    int lat = -1;
    bit ar_done = 1'b0;
    bit ended = 1'b0;
    for (int i = 0; i < 200 && !ended; i++) begin
      @(negedge clk);
      if (i == 0) begin
        refill_req = 1'b1;
        refill_addr = addr;
      end else begin
        refill_addr = ~addr;
      end
      if (rst_at >= 0 && deliv == rst_at) begin
        rst = 1'b1;
        refill_req = 1'b0;
        rvalid = 1'b1;
        beat_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset({tag, "/post_rst"});
        @(negedge clk);
        #1;
        check({tag, "/stray_rready"}, 64'(rready), 64'd0);
        check({tag, "/stray_busy"}, 64'(busy), 64'd0);
        check({tag, "/stray_pulse"}, 64'(line_done | line_err), 64'd0);
        rvalid = 1'b0;
        rlast = 1'b0;
        return;
      end
      arready = aw >= dly;
      rvalid = ar_done && sb < nb;
      rdata = 64'(sb) * 64'h1111;
      rlast = sb == last_i;
      rresp = sb == err_b ? 2'b10 : 2'b00;
      beat_ready = bp != 0 ? (i % 3 == 0) : 1'b1;
      #1;
      if (arvalid) begin
        check({tag, "/araddr"}, araddr, exp_ar);
        if (arready) begin
          ar_done = 1'b1;
          check({tag, "/arlen"}, 64'(arlen), 64'd7);
          check({tag, "/arsize"}, 64'(arsize), 64'd3);
          check({tag, "/arburst"}, 64'(arburst), 64'd1);
          check({tag, "/arid"}, 64'(arid), 64'd0);
        end else begin
          aw++;
        end
      end
      if (beat_valid) begin
        check({tag, "/beat_idx"}, 64'(beat_idx), 64'(deliv));
        check({tag, "/beat_data"}, beat_data, 64'(deliv) * 64'h1111);
        if (beat_ready) deliv++;
      end
      if (rvalid && rready) begin
        sb++;
        if (!beat_valid) drain++;
      end
      if (line_done || line_err) begin
        nd += int'(line_done);
        ne += int'(line_err);
        lat = i;
        check({tag, "/busy_pulse"}, 64'(busy), 64'd1);
        refill_req = 1'b0;
        ended = 1'b1;
      end
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      rvalid = 1'b0;
      rlast = 1'b0;
      arready = 1'b0;
      #1;
      nd += int'(line_done);
      ne += int'(line_err);
    end
    check({tag, "/ended"}, 64'(ended), 64'd1);
    check({tag, "/delivered"}, 64'(deliv), 64'(exp_deliv));
    check({tag, "/drained"}, 64'(drain), 64'(exp_drain));
    check({tag, "/done_cnt"}, 64'(nd), 64'(exp_done));
    check({tag, "/err_cnt"}, 64'(ne), 64'(exp_err));
    check({tag, "/busy_end"}, 64'(busy), 64'd0);
    check({tag, "/arvalid_end"}, 64'(arvalid), 64'd0);
    if (exp_lat >= 0) check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset("reset");
    run("clean", 64'h8000_1234, 64'h8000_1200, 0, 0, 8, 7, -1, 8, 0, 1, 0, 10, -1);
    run("backpressure", 64'hDEAD_BEFF, 64'hDEAD_BEC0, 3, 1, 8, 7, -1, 8, 0, 1, 0, -1, -1);
    run("slverr", 64'h0000_0040, 64'h0000_0040, 0, 0, 8, 7, 3, 8, 0, 0, 1, 10, -1);
    run("early_last", 64'h0000_2010, 64'h0000_2000, 0, 0, 6, 5, -1, 6, 0, 0, 1, 8, -1);
    run("after_err", 64'h0000_1000, 64'h0000_1000, 0, 0, 8, 7, -1, 8, 0, 1, 0, 10, -1);
    run("missing_last", 64'h0000_3000, 64'h0000_3000, 0, 0, 10, 9, -1, 8, 2, 0, 1, 12, -1);
    run("reset_mid", 64'h0000_5000, 64'h0000_5000, 0, 0, 8, 7, -1, 0, 0, 0, 0, -1, 3);
    run("after_rst", 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDC0, 0, 0, 8, 7, -1, 8, 0, 1, 0, 10, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/icache_refill_axi.md
Name: icache_refill_axi

Overview:
- AXI4 read-burst master between the instruction cache miss logic and the memory bus.
- Latches a miss address, aligns it to a 64-byte line, and issues one INCR burst of 8 x 64-bit beats.
- Forwards each returned beat to the cache's way RAM with a beat index.
- Signals line completion, or a bus error, back to the cache.

Parameters:
- LINE_BYTES, 64, cache line size in bytes; the burst covers exactly one line.
- DATA_W, 64, AXI data width in bits; beats per line = LINE_BYTES*8/DATA_W = 8.
- AXI_ID, 0, constant value driven on arid.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- refill_req  in  1  level request from the cache; held high until line_done or line_err.
- refill_addr  in  64  miss address; sampled only on request acceptance.
- beat_data  out  64  current line beat.
- beat_valid  out  1  beat_data/beat_idx valid this cycle.
- beat_ready  in  1  cache can accept the beat this cycle.
- beat_idx  out  3  beat number 0..7 within the line.
- line_done  out  1  one-cycle pulse: all 8 beats delivered with OKAY response.
- line_err  out  1  one-cycle pulse: burst ended with error or protocol violation.
- busy  out  1  high from acceptance until the done/err pulse, inclusive.
- arvalid  out  1  AXI read address valid.
- arready  in  1  AXI read address ready.
- araddr  out  64  line-aligned address: refill_addr with bits [5:0] cleared.
- arlen  out  8  constant 7.
- arsize  out  3  constant 3 (8 bytes).
- arburst  out  2  constant 2'b01 (INCR).
- arid  out  4  AXI_ID.
- rvalid  in  1  AXI read data valid.
- rready  out  1  AXI read data ready.
- rdata  in  64  AXI read data.
- rresp  in  2  AXI read response.
- rlast  in  1  AXI last beat.

Behaviour:
- Reset (rst high at a clock edge) gives: state IDLE; arvalid, rready, beat_valid, line_done, line_err, busy all 0; beat_idx 0; araddr 0.
- Reset mid-burst abandons the burst immediately. Stray R beats arriving afterwards are ignored while in IDLE (rready=0), and no done/err pulse is produced.
- State IDLE:
  - If refill_req=1 and no done/err pulse is being driven this cycle, capture the aligned address into araddr, clear the beat counter and the error flag, set busy=1, and go to AR next cycle.
  - refill_req still high in the cycle of a done/err pulse is not accepted again; the cache must drop it for at least one cycle.
- State AR:
  - arvalid=1 and araddr held stable until arready.
  - On arvalid&&arready, arvalid drops next cycle and the state moves to R.
  - Minimum AR latency is 1 cycle after acceptance.
- State R:
  - Combinational pass-through: rready = beat_ready, beat_valid = rvalid, beat_data = rdata, beat_idx = counter.
  - A beat transfers when rvalid&&rready. On transfer the counter increments (3-bit wrap is irrelevant; see below).
  - An rresp other than OKAY (00) on any beat sets a sticky error flag. The beat is still forwarded and the burst is consumed to completion.
  - rlast on a beat with counter!=7 (early last) sets the error flag and ends the burst.
  - counter==7 transferring without rlast sets the error flag. The block then keeps rready=1, with beat_valid forced 0, until a beat with rlast is consumed (drain).
  - Burst end leads to DONE.
- State DONE (1 cycle):
  - Pulse line_done if the error flag is 0, else pulse line_err.
  - busy stays 1 in this cycle, then the state returns to IDLE.
- Latency: with arready and rvalid always high and beat_ready high, request accepted at cycle 0 → arvalid at cycle 1 → beats at cycles 2..9 → line_done at cycle 10.
- Back-pressure: beat_ready low stalls rready. A beat held by rvalid must present the same beat_idx until it transfers.
- refill_addr changes after acceptance have no effect. refill_req dropping mid-burst does not abort; the burst completes and pulses as normal.
- rvalid while in IDLE/AR/DONE is never accepted (rready=0).

Test Plan:
- Clean refill: refill_addr=0x8000_1234, bus always ready, rdata=beat*0x1111 → araddr=0x8000_1200, arlen=7, arsize=3, arburst=01; beat_idx 0..7 with matching data; line_done at cycle 10; line_err never.
- Back-pressure: beat_ready toggled 1,0,0,1,… and arready delayed 3 cycles → araddr stable during the wait; each beat delivered exactly once in order; line_done after beat 7; no beat dropped or duplicated.
- Slave error: rresp=2'b10 on beat 3 → all 8 beats forwarded; line_err pulses once; line_done stays 0.
- Early rlast on beat 5 → burst ends after beat 5; line_err pulses; block returns to IDLE and the next request of 0x1000 produces araddr=0x1000.
- Missing rlast: slave sends 10 beats, last on the 10th → beats 0..7 delivered; beats 8..9 consumed with beat_valid=0; then line_err.
- Reset during R after beat 2 → all outputs at reset values the next cycle; the next request starts a fresh AR and delivers beat_idx starting from 0.
